// File: rtl/bit_serial_add_ctrl_if.sv
// Bundle of every non-clock signal of the bit-serial adder controller.
//   slave  : controller view. It receives the requests, drives the datapath and the result.
//   master : environment view. This covers the requesters, the datapath and the result consumer.
// Signals:
//   req0_*/req1_* : per-requester valid/ready handshake, operands a/b and carry-in.
//   dp_*          : parallel load and operands toward the datapath, sum/carry back.
//   res_*         : result handshake with captured sum, carry-out and owner id.
//   busy          : controller is not idle.
interface bit_serial_add_ctrl_if #(
  parameter int N = 8
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req0_cin;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         req1_cin;
  logic         dp_load;
  logic [N-1:0] dp_a;
  logic [N-1:0] dp_b;
  logic         dp_cy_in;
  logic [N-1:0] dp_sum;
  logic         dp_cy_out;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_sum;
  logic         res_cout;
  logic         res_id;
  logic         busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output dp_load, dp_a, dp_b, dp_cy_in,
    input  dp_sum, dp_cy_out,
    output res_valid, res_sum, res_cout, res_id,
    input  res_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  dp_load, dp_a, dp_b, dp_cy_in,
    output dp_sum, dp_cy_out,
    input  res_valid, res_sum, res_cout, res_id,
    output res_ready,
    input  busy
  );
endinterface

// File: rtl/bit_serial_add_ctrl.sv
// Controller for an N-bit bit-serial adder datapath. It arbitrates two requesters
// round-robin, parallel-loads the datapath, counts N shift cycles, captures the sum
// and carry-out, and returns the result tagged with the requester id.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : bit_serial_add_ctrl_if.slave (requests, datapath control, result, busy)
module bit_serial_add_ctrl #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bit_serial_add_ctrl_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;     // requester served most recently
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          cin_q, cin_d;
  logic          id_q, id_d;         // owner of the in-flight operation
  logic          res_valid_q, res_valid_d;
  logic [N-1:0]  res_sum_q, res_sum_d;
  logic          res_cout_q, res_cout_d;
  logic          res_id_q, res_id_d;
  logic          grant0, grant1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;           // requester 0 wins the first tie
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      res_id_q    <= res_id_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    res_id_d    = res_id_q;
    case (state_q)
      S_IDLE: begin
        if (grant0) begin
          a_d     = bus.req0_a;
          b_d     = bus.req0_b;
          cin_d   = bus.req0_cin;
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = S_LOAD;
        end else if (grant1) begin
          a_d     = bus.req1_a;
          b_d     = bus.req1_b;
          cin_d   = bus.req1_cin;
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        // The edge leaving SHIFT with cnt_q == N-1 is the N-th shift edge.
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // The datapath keeps shifting, so this edge is the only one where its sum is whole.
        res_sum_d   = bus.dp_sum;
        res_cout_d  = bus.dp_cy_out;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. The round-robin grant is combinational and only live in IDLE.
  always_comb begin
    grant0      = 1'b0;
    grant1      = 1'b0;
    bus.dp_load = 1'b0;
    bus.busy    = 1'b1;
    case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        grant0   = bus.req0_valid && (!bus.req1_valid || last_q);
        grant1   = bus.req1_valid && (!bus.req0_valid || !last_q);
      end
      S_LOAD:  bus.dp_load = 1'b1;
      default: ;
    endcase
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.dp_a       = a_q;
  assign bus.dp_b       = b_q;
  assign bus.dp_cy_in   = cin_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_sum    = res_sum_q;
  assign bus.res_cout   = res_cout_q;
  assign bus.res_id     = res_id_q;
endmodule
